// File: rtl/axis_round_robin_mux_pkg.sv
// Shared types and helpers for the round-robin AXI stream mux.
// Holds the FSM state encoding, counter width and a clog2 constant function.
package axis_round_robin_mux_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int COUNT_WIDTH = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_round_robin_mux_round_robin_select.sv
// Round-robin winner search over a request vector.
// Double-width masked priority encoder starting just after the last pointer.
module round_robin_select
    import axis_round_robin_mux_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int CHAN_WIDTH   = 2
) (
    input  logic [NUM_CHANNELS-1:0] i_req,
    input  logic [CHAN_WIDTH-1:0]   i_last,
    output logic [CHAN_WIDTH-1:0]   o_winner,
    output logic                    o_any
);

    localparam int DW2   = 2 * NUM_CHANNELS;
    localparam int IDX_W = clog2(DW2) + 1;

    logic [DW2-1:0] w_dbl;
    logic [DW2-1:0] w_masked;

    // Unroll the requests twice and keep only the window last+1 .. last+N.
    always_comb begin
        w_dbl    = {i_req, i_req};
        w_masked = '0;
        for (int i = 0; i < DW2; i++) begin
            if ((i > int'(i_last)) && (i <= int'(i_last) + NUM_CHANNELS)) begin
                w_masked[i] = w_dbl[i];
            end
        end
    end

    // Lowest set bit of the window is the winner; fold the upper copy back.
    always_comb begin
        logic [IDX_W-1:0] w_idx;
        w_idx    = '0;
        o_any    = 1'b0;
        o_winner = '0;
        for (int i = DW2 - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_idx = IDX_W'(i);
                o_any = 1'b1;
            end
        end
        if (int'(w_idx) >= NUM_CHANNELS) begin
            o_winner = CHAN_WIDTH'(int'(w_idx) - NUM_CHANNELS);
        end else begin
            o_winner = CHAN_WIDTH'(w_idx);
        end
    end

endmodule

// File: rtl/axis_round_robin_mux.sv
// Burst-granting round-robin mux of N AXI streams onto one tagged stream.
// Almost-full channels are served first; overflow flags merge into one sticky bit.
module axis_round_robin_mux
    import axis_round_robin_mux_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BURST_LEN    = 8,
    parameter int CHAN_WIDTH   = 2
) (
    input  logic                               clock,
    input  logic                               resetn,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CHANNELS-1:0]            in_valid,
    output logic [NUM_CHANNELS-1:0]            in_ready,
    input  logic [NUM_CHANNELS-1:0]            in_afull,
    input  logic [NUM_CHANNELS-1:0]            in_overflow,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [CHAN_WIDTH-1:0]              out_chan,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               overflow,
    output logic                               busy
);

    localparam logic [COUNT_WIDTH-1:0] LAST_BEAT = COUNT_WIDTH'(BURST_LEN - 1);
    localparam logic [CHAN_WIDTH-1:0]  LAST_RST  = CHAN_WIDTH'(NUM_CHANNELS - 1);

    if (CHAN_WIDTH < clog2(NUM_CHANNELS)) begin : g_bad_chan_width
        $error("CHAN_WIDTH too small for NUM_CHANNELS");
    end
    if (NUM_CHANNELS < 2 || NUM_CHANNELS > 16) begin : g_bad_num_channels
        $error("NUM_CHANNELS out of range 2..16");
    end
    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
        $error("BURST_LEN out of range 1..255");
    end

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CHAN_WIDTH-1:0]    r_grant;
    logic [CHAN_WIDTH-1:0]    w_grant_nxt;
    logic [CHAN_WIDTH-1:0]    r_last;
    logic [CHAN_WIDTH-1:0]    w_last_nxt;
    logic [COUNT_WIDTH-1:0]   r_count;
    logic [COUNT_WIDTH-1:0]   w_count_nxt;

    logic [DATA_WIDTH-1:0]    r_out_data;
    logic [CHAN_WIDTH-1:0]    r_out_chan;
    logic                     r_out_valid;
    logic                     r_overflow;

    logic [DATA_WIDTH-1:0]    w_chan_data [NUM_CHANNELS];
    logic                     w_src_valid;
    logic                     w_accept;
    logic                     w_load;
    logic [NUM_CHANNELS-1:0]  w_urg_req;
    logic [CHAN_WIDTH-1:0]    w_urg_win;
    logic                     w_urg_any;
    logic [CHAN_WIDTH-1:0]    w_norm_win;
    logic                     w_norm_any;
    logic [CHAN_WIDTH-1:0]    w_winner;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan_data
        assign w_chan_data[c] = in_data[c*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_urg_req = in_valid & in_afull;

    round_robin_select #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .CHAN_WIDTH   (CHAN_WIDTH)
    ) u_sel_urgent (
        .i_req    (w_urg_req),
        .i_last   (r_last),
        .o_winner (w_urg_win),
        .o_any    (w_urg_any)
    );

    round_robin_select #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .CHAN_WIDTH   (CHAN_WIDTH)
    ) u_sel_normal (
        .i_req    (in_valid),
        .i_last   (r_last),
        .o_winner (w_norm_win),
        .o_any    (w_norm_any)
    );

    assign w_winner    = w_urg_any ? w_urg_win : w_norm_win;
    assign w_src_valid = in_valid[r_grant];
    assign w_accept    = (r_state == GRANT) && (!r_out_valid || out_ready);
    assign w_load      = w_accept && w_src_valid;

    // Ready goes only to the granted channel and ignores its valid.
    always_comb begin
        in_ready = '0;
        if (w_accept) begin
            in_ready[r_grant] = 1'b1;
        end
    end

    // Arbitrate in IDLE; in GRANT count beats and release on limit or empty source.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_count_nxt = r_count;
        unique case (r_state)
            IDLE: begin
                if (w_norm_any) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_winner;
                    w_last_nxt  = w_winner;
                    w_count_nxt = '0;
                end
            end
            GRANT: begin
                if (w_load) begin
                    w_count_nxt = r_count + 1'b1;
                end
                if ((w_load && (r_count == LAST_BEAT)) || !w_src_valid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM, grant pointer, round-robin pointer and beat counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= LAST_RST;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Single-entry output register; holds while downstream stalls.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_chan_data[r_grant];
            r_out_chan  <= r_grant;
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= r_out_valid && !out_ready;
        end
    end

    // Sticky merge of per-channel overflow flags.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow | (|in_overflow);
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;
    assign busy      = (r_state == GRANT);

endmodule

// File: tb/tb_axis_round_robin_mux.sv
// Self-checking bench for axis_round_robin_mux.
// Queue-based sources, a cycle reference model and a per-channel scoreboard.
module tb_axis_round_robin_mux;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 8;
    localparam int CW = 2;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    in_afull;
    logic [N-1:0]    in_overflow;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_chan;
    logic            out_valid;
    logic            out_ready;
    logic            overflow;
    logic            busy;

    always #5 clock = ~clock;

    axis_round_robin_mux #(
        .NUM_CHANNELS (N),
        .DATA_WIDTH   (DW),
        .BURST_LEN    (BL),
        .CHAN_WIDTH   (CW)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_afull    (in_afull),
        .in_overflow (in_overflow),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .busy        (busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [DW-1:0] src_q [N][$];
    logic [DW-1:0] exp_q [N][$];
    int            acc_order[$];
    int            runs[$];
    int            run_len = 0;

    bit            rst_req   = 1'b1;
    bit            rnd_afull = 1'b0;
    logic [N-1:0]  afull_fix = '0;
    logic [N-1:0]  ovf_pulse = '0;
    int            rdy_mode  = 0;

    bit            m_busy;
    int            m_grant;
    int            m_last;
    int            m_beats;
    bit            m_ov;
    logic [DW-1:0] m_od;
    int            m_oc;
    bit            m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_grant = 0;
        m_last  = N - 1;
        m_beats = 0;
        m_ov    = 1'b0;
        m_od    = '0;
        m_oc    = 0;
        m_ovf   = 1'b0;
    endtask

    function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] a,
                                input int last);
        logic [N-1:0] s;
        s = ((v & a) != '0) ? (v & a) : v;
        for (int k = 1; k <= N; k++) begin
            if (s[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    task automatic push(input int c, input int n);
        for (int i = 0; i < n; i++) src_q[c].push_back(DW'($urandom));
    endtask

    task automatic cycle();
        logic [N-1:0] exp_rdy;
        bit           ld;
        int           ch;
        @(negedge clock);
        resetn = !rst_req;
        for (int c = 0; c < N; c++) begin
            in_valid[c] = (src_q[c].size() > 0);
            in_data[c*DW +: DW] = in_valid[c] ? src_q[c][0] : DW'($urandom);
        end
        in_afull    = rnd_afull ? N'($urandom & $urandom & $urandom) : afull_fix;
        in_overflow = ovf_pulse;
        ovf_pulse   = '0;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
        #1;
        if (!resetn) begin
            model_reset();
            for (int c = 0; c < N; c++) exp_q[c].delete();
        end
        exp_rdy = '0;
        if (m_busy && (!m_ov || out_ready)) exp_rdy[m_grant] = 1'b1;
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_chan", out_chan, m_oc);
        chk("busy", busy, m_busy);
        chk("overflow", overflow, m_ovf);
        chk("in_ready", in_ready, exp_rdy);
        if (resetn && out_valid && out_ready) begin
            ch = int'(out_chan);
            acc_order.push_back(ch);
            chk("sb_has_beat", exp_q[ch].size() != 0, 1);
            if (exp_q[ch].size() != 0) chk("sb_data", out_data, exp_q[ch].pop_front());
        end
        if (out_valid) run_len++;
        else if (run_len > 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
        if (resetn) begin
            for (int c = 0; c < N; c++) begin
                if (in_valid[c] && in_ready[c]) exp_q[c].push_back(src_q[c].pop_front());
            end
            ld = m_busy && (!m_ov || out_ready) && in_valid[m_grant];
            if (ld) begin
                m_od = in_data[m_grant*DW +: DW];
                m_oc = m_grant;
                m_ov = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (!m_busy) begin
                if (in_valid != '0) begin
                    m_grant = pick(in_valid, in_afull, m_last);
                    m_last  = m_grant;
                    m_beats = 0;
                    m_busy  = 1'b1;
                end
            end else begin
                if ((ld && m_beats == BL - 1) || !in_valid[m_grant]) m_busy = 1'b0;
                if (ld) m_beats++;
            end
            if (in_overflow != '0) m_ovf = 1'b1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_order(input string tag, input int exp[$]);
        chk({tag, "_len"}, acc_order.size(), exp.size());
        for (int i = 0; i < exp.size() && i < acc_order.size(); i++)
            chk(tag, acc_order[i], exp[i]);
    endtask

    initial begin
        int ord1[$] = '{0, 0, 1, 1, 2, 2, 3, 3};
        int ord3[$] = '{2, 2, 2, 2, 2, 2, 2, 2, 0, 0, 0, 2, 2};
        int ord5[$] = '{3, 3, 3, 1, 1, 3, 3};
        int runs2[$] = '{8, 8, 4};
        int ord2[$];
        int ord4[$];
        in_data     = '0;
        in_valid    = '0;
        in_afull    = '0;
        in_overflow = '0;
        out_ready   = 1'b0;
        model_reset();

        // reset with every channel holding two beats
        for (int c = 0; c < N; c++) push(c, 2);
        rst_req = 1'b1;
        run(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_chan", out_chan, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_req = 1'b0;
        acc_order.delete();
        run(30);
        chk_order("t1_order", ord1);

        // one long stream split into bursts with bubbles
        acc_order.delete();
        runs.delete();
        run_len = 0;
        push(1, 20);
        run(40);
        chk("t2_runs_n", runs.size(), runs2.size());
        for (int i = 0; i < runs.size() && i < runs2.size(); i++)
            chk("t2_run_len", runs[i], runs2[i]);
        for (int i = 0; i < 20; i++) ord2.push_back(1);
        chk_order("t2_order", ord2);

        // almost-full channel jumps the queue
        rst_req = 1'b1;
        run(2);
        rst_req = 1'b0;
        acc_order.delete();
        push(0, 3);
        push(2, 10);
        afull_fix = 4'b0100;
        run(4);
        afull_fix = '0;
        run(40);
        chk_order("t3_order", ord3);

        // downstream stall mid-burst
        acc_order.delete();
        push(1, 10);
        rdy_mode = 0;
        run(5);
        rdy_mode = 2;
        run(5);
        rdy_mode = 0;
        run(30);
        for (int i = 0; i < 10; i++) ord4.push_back(1);
        chk_order("t4_order", ord4);

        // source runs dry mid-burst, then rejoins
        rst_req = 1'b1;
        run(2);
        rst_req = 1'b0;
        acc_order.delete();
        push(3, 3);
        run(3);
        push(1, 2);
        run(10);
        push(3, 2);
        run(15);
        chk_order("t5_order", ord5);

        // sticky overflow
        ovf_pulse = 4'b0100;
        run(2);
        chk("t6_ovf_set", overflow, 1);
        run(5);
        chk("t6_ovf_sticky", overflow, 1);
        rst_req = 1'b1;
        run(1);
        chk("t6_ovf_clear", overflow, 0);
        rst_req = 1'b0;

        // random traffic with urgent hints, stalls and one reset
        rnd_afull = 1'b1;
        rdy_mode  = 1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) push($urandom_range(0, N - 1), 1);
            rst_req = (i == 250);
            run(1);
        end
        rst_req   = 1'b0;
        rnd_afull = 1'b0;
        rdy_mode  = 0;
        run(300);
        for (int c = 0; c < N; c++) begin
            chk("drain_src", src_q[c].size(), 0);
            chk("drain_sb", exp_q[c].size(), 0);
        end
        chk("drain_out_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
